// File: rtl/wb_master_seq.sv
// Wishbone initiator: takes one command on a valid/ready port, runs a single
// bus cycle (ack or timeout), and returns data/error on a held response port.
module wb_master_seq #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [16:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [16:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_wstb,
  output logic        wb_we,
  output logic        wb_re,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  output logic        busy
);

  // Handshakes: a command transfers on the edge where cmd_valid & cmd_ready;
  // a response transfers on the edge where rsp_valid & rsp_ready. Neither
  // ready depends combinationally on the matching valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [TO_W-1:0] cnt, cnt_nx;
  logic            we_q, we_nx;
  logic [16:0]     addr_nx;
  logic [31:0]     wdata_nx;
  logic [3:0]      wstb_nx;
  logic [31:0]     data_nx;
  logic            err_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      wb_addr  <= '0;
      wb_wdata <= '0;
      wb_wstb  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      we_q     <= we_nx;
      wb_addr  <= addr_nx;
      wb_wdata <= wdata_nx;
      wb_wstb  <= wstb_nx;
      rsp_data <= data_nx;
      rsp_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = we_q;
    addr_nx  = wb_addr;
    wdata_nx = wb_wdata;
    wstb_nx  = wb_wstb;
    data_nx  = rsp_data;
    err_nx   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = BUS;
          cnt_nx   = '0;
          we_nx    = cmd_we;
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          wstb_nx  = cmd_we ? cmd_wstb : 4'hf;
        end
      end
      BUS: begin
        // Ack is checked before the counter so a last-cycle ack still succeeds.
        if (wb_ack) begin
          state_nx = RSP;
          data_nx  = we_q ? 32'h0 : wb_rdata;
          err_nx   = 1'b0;
        end else if (cnt == TO_LAST) begin
          state_nx = RSP;
          data_nx  = 32'h0;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);
  assign wb_cyc    = (state == BUS);
  assign wb_stb    = (state == BUS);
  assign wb_we     = (state == BUS) &  we_q;
  assign wb_re     = (state == BUS) & ~we_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Bench for wb_master_seq: table vectors, randomized commands against a
// rule-level response model, and hand sequences for backpressure and reset.
module tb_wb_master_seq;

  localparam int TIMEOUT = 256;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [16:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [16:0] wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic [3:0]  wb_wstb;
  logic        wb_we, wb_re, wb_cyc, wb_stb, wb_ack, busy;

  wb_master_seq #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstb(cmd_wstb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wstb(wb_wstb),
    .wb_we(wb_we), .wb_re(wb_re), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- responder ----------------
  int          ack_delay;
  int          cyc_cnt;
  logic        spur_ack;
  logic [31:0] rdata_drive;

  always @(posedge clk) cyc_cnt <= wb_cyc ? cyc_cnt + 1 : 0;
  assign wb_ack   = spur_ack | (wb_cyc && (cyc_cnt == ack_delay));
  assign wb_rdata = rdata_drive;

  // ---------------- bus monitor ----------------
  logic        exp_we;
  logic [16:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstb;
  int          cyc_total;
  int          bus_bad;

  always @(posedge clk) begin
    if (wb_cyc) begin
      cyc_total <= cyc_total + 1;
      if (wb_stb !== 1'b1 || wb_addr !== exp_addr || wb_wdata !== exp_wdata ||
          wb_wstb !== exp_wstb || wb_we !== exp_we || wb_re !== !exp_we)
        bus_bad <= bus_bad + 1;
    end else if (wb_stb || wb_we || wb_re) begin
      bus_bad <= bus_bad + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          total, bad;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response rules: ack on any of the first TIMEOUT bus cycles wins,
  // otherwise the cycle runs TIMEOUT cycles and ends with an error.
  task automatic ref_rsp(input logic we, input int delay, input logic [31:0] rdata,
                         output logic err, output logic [31:0] data, output int cycles);
    if (delay < TIMEOUT) begin
      err    = 1'b0;
      data   = we ? 32'h0 : rdata;
      cycles = delay + 1;
    end else begin
      err    = 1'b1;
      data   = 32'h0;
      cycles = TIMEOUT;
    end
  endtask

  // ---------------- driver tasks ----------------
  int snap;

  task automatic issue(input logic we, input logic [16:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstb, input int delay, input logic [31:0] rdata);
    @(negedge clk);
    ack_delay   = delay;
    rdata_drive = rdata;
    exp_we      = we;
    exp_addr    = addr;
    exp_wdata   = wdata;
    exp_wstb    = we ? wstb : 4'hf;
    cmd_we      = we;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_wstb    = wstb;
    cmd_valid   = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1);
    snap = cyc_total;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < TIMEOUT + 20);
    if (!rsp_valid) check("rsp_timeout_bound", 0, 1);
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("after_take", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  task automatic run_cmd(input logic we, input logic [16:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstb, input int delay, input logic [31:0] rdata,
                         input logic exp_err, input logic [31:0] exp_data, input int exp_cyc,
                         input int hold);
    int          lat;
    int          bad0;
    logic [32:0] e;
    exp_q.push_back({exp_err, exp_data});
    bad0 = bus_bad;
    issue(we, addr, wdata, wstb, delay, rdata);
    wait_rsp(lat);
    e = exp_q.pop_front();
    check("rsp_err", rsp_err, e[32]);
    check("rsp_data", rsp_data, e[31:0]);
    check("cyc_cycles", cyc_total - snap, exp_cyc);
    check("latency", lat, exp_cyc + 1);
    check("bus_signals", bus_bad - bad0, 0);
    repeat (hold) @(negedge clk);
    if (hold > 0) check("rsp_held", {rsp_valid, rsp_err, rsp_data}, {1'b1, e});
    take_rsp();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          delay;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    logic        m_err;
    logic [31:0] m_data;
    int          m_cyc;
    logic        r_we;
    int          r_delay, sel;
    logic [31:0] r_rdata;

    total = 0; bad = 0;
    cyc_total = 0; bus_bad = 0;
    rst = 1'b1; spur_ack = 1'b0; ack_delay = 0; rdata_drive = 32'h0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstb = '0;
    rsp_ready = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstb = '0;

    vecs[0] = '{1'b1, 17'h0000C, 32'h12345678, 4'b0011, 2,    32'hDEADBEEF, 1'b0, 32'h0,        3};
    vecs[1] = '{1'b0, 17'h1F000, 32'h0,        4'b0000, 0,    32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1};
    vecs[2] = '{1'b0, 17'h00001, 32'h0,        4'b0000, 1000, 32'h11111111, 1'b1, 32'h0,        256};
    vecs[3] = '{1'b0, 17'h0ABCD, 32'h0,        4'b0000, 255,  32'h5A5A0001, 1'b0, 32'h5A5A0001, 256};
    vecs[4] = '{1'b1, 17'h1FFFF, 32'hA5A5A5A5, 4'b1111, 0,    32'hFFFFFFFF, 1'b0, 32'h0,        1};
    vecs[5] = '{1'b0, 17'h00100, 32'h0,        4'b0101, 5,    32'h00000000, 1'b0, 32'h0,        6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state",
          {cmd_ready, rsp_valid, rsp_err, rsp_data, wb_cyc, wb_stb, wb_we, wb_re, busy},
          {1'b1, 1'b0, 1'b0, 32'h0, 5'b0});
    check("reset_bus_regs", {wb_addr, wb_wdata, wb_wstb}, 53'h0);

    // table vectors
    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstb, vecs[i].delay,
              vecs[i].rdata, vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_cyc, i % 3);

    // randomized commands against the reference model
    for (int i = 0; i < 25; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_rdata = $urandom;
      sel     = $urandom_range(0, 9);
      if (sel < 7)       r_delay = $urandom_range(0, 6);
      else if (sel == 7) r_delay = TIMEOUT - 1;
      else if (sel == 8) r_delay = TIMEOUT;
      else               r_delay = TIMEOUT + 3;
      ref_rsp(r_we, r_delay, r_rdata, m_err, m_data, m_cyc);
      run_cmd(r_we, 17'($urandom), $urandom, 4'($urandom), r_delay, r_rdata,
              m_err, m_data, m_cyc, $urandom_range(0, 3));
    end

    // backpressure: response held 10 cycles while the next command waits
    issue(1'b0, 17'h00042, 32'h0, 4'h0, 1, 32'h0BADBEEF);
    wait_rsp(lat);
    check("bp_first_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0BADBEEF});
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 17'h00043; cmd_wdata = 32'h87654321; cmd_wstb = 4'b1100;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, cmd_ready, wb_cyc, rsp_err, rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADBEEF});
    end
    exp_we = 1'b1; exp_addr = 17'h00043; exp_wdata = 32'h87654321; exp_wstb = 4'b1100;
    ack_delay = 0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_after_take", {rsp_valid, cmd_ready, wb_cyc}, 3'b010);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_second_cycle", {wb_cyc, wb_we, wb_re, wb_wstb}, {3'b110, 4'b1100});
    wait_rsp(lat);
    check("bp_second_rsp", {rsp_err, rsp_data}, 33'h0);
    take_rsp();

    // reset in the middle of a bus cycle, then a spurious ack
    issue(1'b0, 17'h00077, 32'h0, 4'h0, 1000, 32'h13572468);
    repeat (5) @(negedge clk);
    check("pre_reset_cyc", wb_cyc, 1);
    rst = 1'b1;
    #1;
    check("reset_midcycle", {wb_cyc, wb_stb, wb_re, rsp_valid, busy}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    spur_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("spurious_ack", {rsp_valid, busy, wb_cyc, cmd_ready}, 4'b0001);
    end
    spur_ack = 1'b0;
    run_cmd(1'b0, 17'h00078, 32'h0, 4'h0, 3, 32'h24681357, 1'b0, 32'h24681357, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
